uart_xcvr_param: RTL and testbench

//  Parametrised full-duplex UART transceiver; next generation of the fixed 8-bit UART cell.

---
 rtl/uart_xcvr_param.sv | 256 +++++++++++++++++++++++++
 tb/tb_uart_xcvr_param.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_xcvr_param.sv
// uart_xcvr_param -- parametrised full-duplex UART transceiver.
//
// Sends and receives DATA_W-bit frames with optional even/odd parity and
// 1 or 2 stop bits. A shared 16x-oversampling tick drives both directions.
// RX takes a 2-of-3 majority of ticks 7/8/9 of every bit.
//
// Ports:
//   clk, rst_n           clock (rising edge), asynchronous active-low reset
//   baud_sel[1:0]        00=9600 01=19200 10=38400 11=115200
//   par_mode[1:0]        00/11=none 01=even 10=odd
//   tx_data/valid/ready  transmit handshake; tx is the serial output (idle high)
//   rx                   asynchronous serial input
//   rx_data/valid/ready  receive handshake; rx_perr/rx_ferr qualify the held word
//   rx_ovr               1-cycle pulse when a completed frame is dropped
//   busy                 a TX or RX frame is in progress
module uart_xcvr_param #(
  parameter int DATA_W    = 8,
  parameter int CLK_HZ    = 4_915_200,
  parameter int STOP_BITS = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        baud_sel,
  input  logic [1:0]        par_mode,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              tx,
  input  logic              rx,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic              rx_ready,
  output logic              rx_perr,
  output logic              rx_ferr,
  output logic              rx_ovr,
  output logic              busy
);

  // Rounded divider CLK_HZ / (16 * baud), never below 1.
  function automatic int div_for(input int baud);
    int d;
    d = (CLK_HZ + 8 * baud) / (16 * baud);
    if (d < 1) d = 1;
    return d;
  endfunction

  localparam int DIV_MAX = div_for(9600);
  localparam int CNT_W   = (DIV_MAX > 1) ? $clog2(DIV_MAX) : 1;
  localparam logic [CNT_W-1:0] DM1_0 = CNT_W'(div_for(9600) - 1);
  localparam logic [CNT_W-1:0] DM1_1 = CNT_W'(div_for(19200) - 1);
  localparam logic [CNT_W-1:0] DM1_2 = CNT_W'(div_for(38400) - 1);
  localparam logic [CNT_W-1:0] DM1_3 = CNT_W'(div_for(115200) - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_PAR   = 3'd3;
  localparam logic [2:0] S_STOP  = 3'd4;

  localparam logic [3:0] LAST_BIT  = 4'(DATA_W - 1);
  // TX leaves STOP one tick early so a queued word starts with no idle gap.
  localparam logic [4:0] STOP_LAST = 5'(STOP_BITS * 16 - 2);

  logic [1:0]       cfg_baud, cfg_par;
  logic [CNT_W-1:0] tick_cnt, div_m1;
  logic             tick, cfg_load, par_en, par_odd, both_idle;

  logic [2:0]        tx_state;
  logic              tx_arm, tx_xor;
  logic [4:0]        tx_tcnt;
  logic [3:0]        tx_bit;
  logic [DATA_W-1:0] tx_sh;

  logic              rx_s1, rx_s2, rx_prev;
  logic [2:0]        rx_state;
  logic [4:0]        rx_tcnt, rx_new;
  logic [3:0]        rx_bit;
  logic [1:0]        rx_smp;
  logic [DATA_W-1:0] rx_sh;
  logic              rx_pe, rx_maj, smp_ev, maj_ev, end_ev, rx_done;

  always_comb begin
    case (cfg_baud)
      2'b00:   div_m1 = DM1_0;
      2'b01:   div_m1 = DM1_1;
      2'b10:   div_m1 = DM1_2;
      default: div_m1 = DM1_3;
    endcase
  end

  assign tick      = (tick_cnt == div_m1);
  assign tx_ready  = (tx_state == S_IDLE);
  assign both_idle = tx_ready && (rx_state == S_IDLE);
  assign cfg_load  = both_idle && ({baud_sel, par_mode} != {cfg_baud, cfg_par});
  assign par_en    = (cfg_par == 2'b01) || (cfg_par == 2'b10);
  assign par_odd   = (cfg_par == 2'b10);
  assign busy      = !tx_ready || (rx_state != S_IDLE);

  // Configuration and tick generator
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg_baud <= 2'b00;
      cfg_par  <= 2'b00;
      tick_cnt <= '0;
    end else begin
      if (cfg_load) begin
        cfg_baud <= baud_sel;
        cfg_par  <= par_mode;
      end
      if (cfg_load || tick) tick_cnt <= '0;
      else                  tick_cnt <= tick_cnt + 1'b1;
    end
  end

  // Transmit FSM; START waits unarmed until the first tick after the transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state <= S_IDLE;
      tx_arm   <= 1'b0;
      tx_tcnt  <= '0;
      tx_bit   <= '0;
    end else begin
      case (tx_state)
        S_IDLE: if (tx_valid) begin
          tx_state <= S_START;
          tx_arm   <= 1'b0;
        end
        S_START: if (tick) begin
          if (!tx_arm) begin
            tx_arm  <= 1'b1;
            tx_tcnt <= '0;
          end else if (tx_tcnt == 5'd15) begin
            tx_state <= S_DATA;
            tx_tcnt  <= '0;
            tx_bit   <= '0;
          end else tx_tcnt <= tx_tcnt + 5'd1;
        end
        S_DATA: if (tick) begin
          if (tx_tcnt == 5'd15) begin
            tx_tcnt <= '0;
            if (tx_bit == LAST_BIT) tx_state <= par_en ? S_PAR : S_STOP;
            else                    tx_bit   <= tx_bit + 4'd1;
          end else tx_tcnt <= tx_tcnt + 5'd1;
        end
        S_PAR: if (tick) begin
          if (tx_tcnt == 5'd15) begin
            tx_state <= S_STOP;
            tx_tcnt  <= '0;
          end else tx_tcnt <= tx_tcnt + 5'd1;
        end
        S_STOP: if (tick) begin
          if (tx_tcnt == STOP_LAST) tx_state <= S_IDLE;
          else                      tx_tcnt  <= tx_tcnt + 5'd1;
        end
        default: tx_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (tx_ready && tx_valid) begin
      tx_sh  <= tx_data;
      tx_xor <= ^tx_data;
    end else if (tx_state == S_DATA && tick && tx_tcnt == 5'd15) begin
      tx_sh <= tx_sh >> 1;
    end
  end

  always_comb begin
    case (tx_state)
      S_START: tx = ~tx_arm;
      S_DATA:  tx = tx_sh[0];
      S_PAR:   tx = tx_xor ^ par_odd;
      default: tx = 1'b1;
    endcase
  end

  // Receive synchroniser and FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_s1   <= 1'b1;
      rx_s2   <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_s1   <= rx;
      rx_s2   <= rx_s1;
      rx_prev <= rx_s2;
    end
  end

  assign rx_new = rx_tcnt + 5'd1;
  assign smp_ev = tick && (rx_new == 5'd7 || rx_new == 5'd8);
  assign maj_ev = tick && (rx_new == 5'd9);
  assign end_ev = tick && (rx_new == 5'd16);
  assign rx_maj = (rx_smp[1] & rx_smp[0]) | (rx_smp[1] & rx_s2) | (rx_smp[0] & rx_s2);
  assign rx_done = (rx_state == S_STOP) && maj_ev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_state <= S_IDLE;
      rx_tcnt  <= '0;
      rx_bit   <= '0;
    end else begin
      case (rx_state)
        S_IDLE: if (rx_prev && !rx_s2) begin
          rx_state <= S_START;
          rx_tcnt  <= '0;
        end
        S_START: begin
          if (maj_ev && rx_maj) rx_state <= S_IDLE;
          else if (end_ev) begin
            rx_state <= S_DATA;
            rx_bit   <= '0;
          end
        end
        S_DATA: if (end_ev) begin
          if (rx_bit == LAST_BIT) rx_state <= par_en ? S_PAR : S_STOP;
          else                    rx_bit   <= rx_bit + 4'd1;
        end
        S_PAR:  if (end_ev) rx_state <= S_STOP;
        S_STOP: if (maj_ev) rx_state <= S_IDLE;
        default: rx_state <= S_IDLE;
      endcase
      if (rx_state != S_IDLE && tick) rx_tcnt <= end_ev ? 5'd0 : rx_new;
    end
  end

  always_ff @(posedge clk) begin
    if (rx_state == S_IDLE) rx_pe <= 1'b0;
    if (smp_ev) rx_smp <= {rx_smp[0], rx_s2};
    if (rx_state == S_DATA && maj_ev) rx_sh <= {rx_maj, rx_sh[DATA_W-1:1]};
    if (rx_state == S_PAR && maj_ev) rx_pe <= (^rx_sh) ^ rx_maj ^ par_odd;
  end

  // Delivery: a completing frame loads when the holding slot is free or being drained.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_valid <= 1'b0;
      rx_data  <= '0;
      rx_perr  <= 1'b0;
      rx_ferr  <= 1'b0;
      rx_ovr   <= 1'b0;
    end else begin
      rx_ovr <= rx_done && rx_valid && !rx_ready;
      if (rx_done && (!rx_valid || rx_ready)) begin
        rx_valid <= 1'b1;
        rx_data  <= rx_sh;
        rx_perr  <= rx_pe;
        rx_ferr  <= ~rx_maj;
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_xcvr_param.sv
// Testbench for uart_xcvr_param: two instances (A, B) with a selectable
// line source for A's rx (loopback, B's tx, or bench-driven bit stream).
module tb_uart_xcvr_param;
  localparam int BITC = 256;  // clocks per bit at baud_sel=01

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [1:0] baud_sel = 2'b01;
  logic [1:0] par_mode = 2'b00;
  logic [1:0] src = 2'd0;
  logic       inj = 1'b1;

  logic [7:0] tx_data_a = '0, tx_data_b = '0;
  logic       tx_valid_a = 1'b0, tx_valid_b = 1'b0;
  logic       rx_ready_a = 1'b1, rx_ready_b = 1'b1;
  logic       tx_ready_a, tx_ready_b, tx_a, tx_b, rx_a, rx_b;
  logic [7:0] rx_data_a, rx_data_b;
  logic       rx_valid_a, rx_valid_b, rx_perr_a, rx_perr_b, rx_ferr_a, rx_ferr_b;
  logic       rx_ovr_a, rx_ovr_b, busy_a, busy_b;

  assign rx_a = (src == 2'd0) ? tx_a : (src == 2'd1) ? tx_b : inj;
  assign rx_b = (src == 2'd1) ? tx_a : 1'b1;

  uart_xcvr_param u_a (
    .clk(clk), .rst_n(rst_n), .baud_sel(baud_sel), .par_mode(par_mode),
    .tx_data(tx_data_a), .tx_valid(tx_valid_a), .tx_ready(tx_ready_a), .tx(tx_a),
    .rx(rx_a), .rx_data(rx_data_a), .rx_valid(rx_valid_a), .rx_ready(rx_ready_a),
    .rx_perr(rx_perr_a), .rx_ferr(rx_ferr_a), .rx_ovr(rx_ovr_a), .busy(busy_a));

  uart_xcvr_param u_b (
    .clk(clk), .rst_n(rst_n), .baud_sel(baud_sel), .par_mode(par_mode),
    .tx_data(tx_data_b), .tx_valid(tx_valid_b), .tx_ready(tx_ready_b), .tx(tx_b),
    .rx(rx_b), .rx_data(rx_data_b), .rx_valid(rx_valid_b), .rx_ready(rx_ready_b),
    .rx_perr(rx_perr_b), .rx_ferr(rx_ferr_b), .rx_ovr(rx_ovr_b), .busy(busy_b));

  typedef struct packed {
    logic [7:0] d;
    logic       pe;
    logic       fe;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  int   rise_q[$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   ovr_cnt = 0;
  int   cyc = 0;
  logic prev_rdy_a = 1'b1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Monitor: pops the scoreboard on every RX handshake.
  always @(negedge clk) begin : monitor
    exp_t e;
    cyc++;
    if (rx_ovr_a) ovr_cnt++;
    if (tx_ready_a && !prev_rdy_a) rise_q.push_back(cyc);
    prev_rdy_a = tx_ready_a;
    if (rx_valid_a && rx_ready_a) begin
      if (qa.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL rx_a_unexpected: got %0h, expected no word", rx_data_a);
      end else begin
        e = qa.pop_front();
        check("rx_a_data", 32'(rx_data_a), 32'(e.d));
        check("rx_a_perr", 32'(rx_perr_a), 32'(e.pe));
        check("rx_a_ferr", 32'(rx_ferr_a), 32'(e.fe));
      end
    end
    if (rx_valid_b && rx_ready_b) begin
      if (qb.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL rx_b_unexpected: got %0h, expected no word", rx_data_b);
      end else begin
        e = qb.pop_front();
        check("rx_b_data", 32'(rx_data_b), 32'(e.d));
        check("rx_b_perr", 32'(rx_perr_b), 32'(e.pe));
        check("rx_b_ferr", 32'(rx_ferr_b), 32'(e.fe));
      end
    end
  end

  task automatic send(input bit which, input logic [7:0] d);
    int n = 0;
    @(negedge clk);
    if (which) begin tx_data_b = d; tx_valid_b = 1'b1; end
    else       begin tx_data_a = d; tx_valid_a = 1'b1; end
    while (!(which ? tx_ready_b : tx_ready_a) && n < 6000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 6000) begin
      n_chk++; n_fail++;
      $display("FAIL send_timeout: got tx_ready=0, expected 1 within 6000 cycles");
    end
    @(posedge clk);
    #1;
    if (which) tx_valid_b = 1'b0;
    else       tx_valid_a = 1'b0;
  endtask

  task automatic inject(input logic [7:0] d, input bit use_par, input logic pbit, input logic stopv);
    inj = 1'b0;
    repeat (BITC) @(posedge clk);
    for (int i = 0; i < 8; i++) begin
      inj = d[i];
      repeat (BITC) @(posedge clk);
    end
    if (use_par) begin
      inj = pbit;
      repeat (BITC) @(posedge clk);
    end
    inj = stopv;
    repeat (BITC) @(posedge clk);
    inj = 1'b1;
    repeat (BITC) @(posedge clk);
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((qa.size() != 0 || qb.size() != 0) && n < 8000) begin
      @(negedge clk);
      n++;
    end
    if (qa.size() != 0 || qb.size() != 0) begin
      n_chk++; n_fail++;
      $display("FAIL drain_timeout: got %0d words pending, expected 0", qa.size() + qb.size());
      qa.delete();
      qb.delete();
    end
  endtask

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: got no end of test, expected finish before 90000 cycles");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int ovr0;
    repeat (5) @(negedge clk);
    check("rst_tx", 32'(tx_a), 32'd1);
    check("rst_tx_ready", 32'(tx_ready_a), 32'd1);
    check("rst_rx_valid", 32'(rx_valid_a), 32'd0);
    check("rst_rx_data", 32'(rx_data_a), 32'd0);
    check("rst_perr", 32'(rx_perr_a), 32'd0);
    check("rst_ferr", 32'(rx_ferr_a), 32'd0);
    check("rst_ovr", 32'(rx_ovr_a), 32'd0);
    check("rst_busy", 32'(busy_a), 32'd0);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);

    // Loopback, no parity
    qa.push_back('{d: 8'h78, pe: 1'b0, fe: 1'b0});
    send(1'b0, 8'h78);
    wait_drain();
    repeat (300) @(negedge clk);
    check("loop_idle_busy", 32'(busy_a), 32'd0);

    // Cross-wired pair, even parity, simultaneous sends
    par_mode = 2'b01;
    repeat (5) @(negedge clk);
    src = 2'd1;
    repeat (2) @(negedge clk);
    qa.push_back('{d: 8'h2C, pe: 1'b0, fe: 1'b0});
    qb.push_back('{d: 8'h16, pe: 1'b0, fe: 1'b0});
    fork
      send(1'b0, 8'h16);
      send(1'b1, 8'h2C);
    join
    wait_drain();
    repeat (300) @(negedge clk);

    // Odd parity mode: even-parity frame is flagged, correct odd frame is clean
    par_mode = 2'b10;
    src = 2'd2;
    repeat (5) @(negedge clk);
    qa.push_back('{d: 8'h01, pe: 1'b1, fe: 1'b0});
    inject(8'h01, 1'b1, 1'b1, 1'b1);
    wait_drain();
    qa.push_back('{d: 8'h03, pe: 1'b0, fe: 1'b0});
    inject(8'h03, 1'b1, 1'b1, 1'b1);
    wait_drain();

    // Stop bit forced low
    par_mode = 2'b00;
    repeat (5) @(negedge clk);
    qa.push_back('{d: 8'hA5, pe: 1'b0, fe: 1'b1});
    inject(8'hA5, 1'b0, 1'b0, 1'b0);
    wait_drain();

    // Overrun with back-to-back loopback frames
    src = 2'd0;
    @(posedge clk);
    #1 rx_ready_a = 1'b0;
    ovr0 = ovr_cnt;
    rise_q.delete();
    qa.push_back('{d: 8'h11, pe: 1'b0, fe: 1'b0});
    send(1'b0, 8'h11);
    send(1'b0, 8'h22);
    for (int n = 0; n < 6000 && ovr_cnt == ovr0; n++) @(negedge clk);
    repeat (300) @(negedge clk);
    check("ovr_pulses", 32'(ovr_cnt - ovr0), 32'd1);
    check("ovr_held_valid", 32'(rx_valid_a), 32'd1);
    check("ovr_held_data", 32'(rx_data_a), 32'h11);
    check("b2b_frame_cycles", (rise_q.size() >= 2) ? 32'(rise_q[1] - rise_q[0]) : 32'd0, 32'd2560);
    @(posedge clk);
    #1 rx_ready_a = 1'b1;
    wait_drain();
    repeat (3) @(negedge clk);
    check("ovr_cleared_valid", 32'(rx_valid_a), 32'd0);

    // Start glitch of 4 ticks
    src = 2'd2;
    repeat (5) @(negedge clk);
    inj = 1'b0;
    repeat (64) @(posedge clk);
    inj = 1'b1;
    repeat (3000) @(negedge clk);
    check("glitch_valid", 32'(rx_valid_a), 32'd0);
    check("glitch_busy", 32'(busy_a), 32'd0);

    // Asynchronous reset in the middle of a loopback frame
    src = 2'd0;
    ovr0 = ovr_cnt;
    send(1'b0, 8'hC3);
    repeat (600) @(negedge clk);
    check("midtx_busy", 32'(busy_a), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_tx", 32'(tx_a), 32'd1);
    check("rst_mid_tx_ready", 32'(tx_ready_a), 32'd1);
    check("rst_mid_busy", 32'(busy_a), 32'd0);
    repeat (3) @(negedge clk);
    check("rst_hold_tx", 32'(tx_a), 32'd1);
    rst_n = 1'b1;
    repeat (3000) @(negedge clk);
    check("rst_no_ovr", 32'(ovr_cnt - ovr0), 32'd0);
    check("rst_no_valid", 32'(rx_valid_a), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
